pipe_step_ctrl: RTL and testbench

Synchronous clock-enable generator for the FPGA pipeline build. It replaces the ripple-divided clock with a single-clock design: the pipeline runs on `clk` and advances only on the cycles where `cpu_en` is high. It provides a free-running mode, where `cpu_en` pulses every DIV_LIMIT+1 cycles, and a single-step mode driven by a debounced board push-button. It sits between the board clock/buttons and the pipeline's register enables.

---
 rtl/pipe_step_ctrl_pkg.sv | 30 +++
 rtl/pipe_step_ctrl_btn_debounce.sv | 69 ++++++
 rtl/pipe_step_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_step_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_clk_pkg
// Description : Shared types and defaults for the pipeline step controller.
//               Holds the FSM state encoding (also driven onto the debug LEDs)
//               and the default divider / debounce limits.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_clk_pkg;

   // State encoding is visible on state_dbg, so values are fixed explicitly.
   typedef enum logic [1:0] {
      S_STEP = 2'b00,
      S_RUN  = 2'b01,
      S_HALT = 2'b10
   } state_t;

   // Run-mode period of 2^16 cycles reproduces the old ripple divider rate.
   localparam int DIV_LIMIT_DEF = 65535;

   // Roughly 5 ms of required stability at a 50 MHz board clock.
   localparam int DEB_LIMIT_DEF = 250000;

   // Bits needed for a counter that must reach 'limit'; never less than one.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage : pipe_clk_pkg
`default_nettype wire

// File: rtl/pipe_step_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, stability-counter debouncer and
//               rising-edge detector for one bouncy, asynchronous push-button.
//               btn_level is the accepted (debounced) button state; btn_rise
//               is a one-cycle pulse in the cycle btn_level becomes 1.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
   import pipe_clk_pkg::*;
#(
   parameter int DEB_LIMIT = DEB_LIMIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise
);

   localparam int             DW      = cnt_width(DEB_LIMIT);
   localparam logic [DW-1:0]  DEB_MAX = DW'(DEB_LIMIT);

   logic          sync_meta;
   logic          sync_btn;
   logic [DW-1:0] deb_cnt;
   logic          differ;
   logic          flip;

   // The synced input disagrees with the accepted state; once this has held
   // for DEB_LIMIT+1 consecutive cycles the change is accepted.
   assign differ = sync_btn ^ btn_level;
   assign flip   = differ && (deb_cnt == DEB_MAX);

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_btn  <= 1'b0;
      end else begin
         sync_meta <= btn_in;
         sync_btn  <= sync_meta;
      end
   end

   // Stability counter, accepted level and press-edge pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb_cnt   <= '0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
      end else begin
         // Only an accepted 0->1 change is a press; a release is silent.
         btn_rise <= flip & ~btn_level;
         if (flip) begin
            btn_level <= ~btn_level;
            deb_cnt   <= '0;
         end else if (differ) begin
            deb_cnt   <= deb_cnt + DW'(1);
         end else begin
            // Any bounce back to the accepted level restarts the wait.
            deb_cnt   <= '0;
         end
      end
   end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/pipe_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_step_ctrl
// Description : Single-clock advance-enable generator for the pipeline.
//               cpu_en is a registered one-cycle enable produced either every
//               DIV_LIMIT+1 cycles (free-run) or once per debounced button
//               press (single-step). A halt request parks the controller in
//               S_HALT until the run switch is returned to single-step.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_step_ctrl
   import pipe_clk_pkg::*;
#(
   parameter int DIV_LIMIT = DIV_LIMIT_DEF,
   parameter int DEB_LIMIT = DEB_LIMIT_DEF,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_mode,
   input  logic             step_btn,
   input  logic             halt,
   output logic             cpu_en,
   output logic [CNT_W-1:0] step_count,
   output logic [1:0]       state_dbg
);

   localparam int            VW      = cnt_width(DIV_LIMIT);
   localparam logic [VW-1:0] DIV_MAX = VW'(DIV_LIMIT);

   logic          run_meta;
   logic          run_sync;
   logic          btn_level;
   logic          btn_rise;
   logic          step_req;
   logic [VW-1:0] div_cnt;
   logic          tick;
   logic          enter_run;
   logic          en_next;
   state_t        state;
   state_t        next_state;

   // Step-button conditioning: synchronize, debounce, detect the press edge.
   btn_debounce #(
      .DEB_LIMIT (DEB_LIMIT)
   ) u_step_btn (
      .clk       (clk),
      .reset     (reset),
      .btn_in    (step_btn),
      .btn_level (btn_level),
      .btn_rise  (btn_rise)
   );

   // The press edge coincides with the level going high; requiring both keeps
   // a request tied to a button that is actually held down.
   assign step_req = btn_rise & btn_level;

   // Two-flop synchronizer for the asynchronous run/step switch.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_meta <= 1'b0;
         run_sync <= 1'b0;
      end else begin
         run_meta <= run_mode;
         run_sync <= run_meta;
      end
   end

   assign tick      = (div_cnt == DIV_MAX);
   assign enter_run = (next_state == S_RUN) && (state != S_RUN);

   // Free-running divider; restarted on run entry so the first run pulse is a
   // full period after the switch is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (enter_run || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + VW'(1);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_STEP;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and next-enable decode; halt overrides every other event.
   always_comb begin
      next_state = state;
      en_next    = 1'b0;
      if (halt) begin
         next_state = S_HALT;
      end else begin
         case (state)
            S_STEP: begin
               en_next = step_req;
               if (run_sync) begin
                  next_state = S_RUN;
               end
            end
            S_RUN: begin
               // Button presses are deliberately ignored while free-running.
               en_next = tick;
               if (!run_sync) begin
                  next_state = S_STEP;
               end
            end
            S_HALT: begin
               // Leaving halt needs the switch in step mode, so the pipeline
               // never resumes free-running without an operator action.
               if (!run_sync) begin
                  next_state = S_STEP;
               end
            end
            default: begin
               next_state = S_STEP;
            end
         endcase
      end
   end

   // Registered enable and pulse counter; the count updates on the same edge
   // that raises cpu_en.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_en     <= 1'b0;
         step_count <= '0;
      end else begin
         cpu_en <= en_next;
         if (en_next) begin
            step_count <= step_count + CNT_W'(1);
         end
      end
   end

   assign state_dbg = state;

endmodule : pipe_step_ctrl
`default_nettype wire

// File: tb/tb_pipe_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_step_ctrl
// Description : Self-checking bench for pipe_step_ctrl (DIV_LIMIT=7,
//               DEB_LIMIT=3, CNT_W=4). Stimulus pushes each expected cpu_en
//               pulse (count, state, timing window) into a queue; a monitor
//               pops and checks every pulse the DUT produces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_step_ctrl;

   logic       clk;
   logic       reset;
   logic       run_mode;
   logic       step_btn;
   logic       halt;
   logic       cpu_en;
   logic [3:0] step_count;
   logic [1:0] state_dbg;

   typedef struct {
      logic [3:0] cnt;
      logic [1:0] st;
      int         lo;
      int         hi;
      bit         rel;   // 1: must arrive exactly 8 cycles after previous pulse
   } exp_t;

   exp_t       exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         last_pulse = -100;
   logic [3:0] exp_count = 4'd0;

   pipe_step_ctrl #(
      .DIV_LIMIT (7),
      .DEB_LIMIT (3),
      .CNT_W     (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run_mode   (run_mode),
      .step_btn   (step_btn),
      .halt       (halt),
      .cpu_en     (cpu_en),
      .step_count (step_count),
      .state_dbg  (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter, advanced on each active edge.
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      n_tests = n_tests + 1;
      if (got !== want) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic push_exp(input logic [1:0] st, input int lo, input int hi, input bit rel);
      exp_t e;
      exp_count = exp_count + 4'd1;
      e.cnt = exp_count;
      e.st  = st;
      e.lo  = lo;
      e.hi  = hi;
      e.rel = rel;
      exp_q.push_back(e);
   endtask

   task automatic check_drained(input string name);
      chk(name, 16'(exp_q.size()), 16'd0);
      exp_q.delete();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One clean press: pulse expected within 9 cycles of the press.
   task automatic step_press(input int hold, input int rel);
      push_exp(2'b00, cyc + 1, cyc + 9, 1'b0);
      step_btn = 1'b1;
      wait_cycles(hold);
      step_btn = 1'b0;
      wait_cycles(rel);
   endtask

   // Scoreboard monitor: every cpu_en pulse must match the head of the queue.
   always @(negedge clk) begin
      if (cpu_en) begin
         if (exp_q.size() == 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, required none (count %0d state %0d)",
                     cyc, step_count, state_dbg);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_count", 16'(step_count), 16'(e.cnt));
            chk("pulse_state", 16'(state_dbg), 16'(e.st));
            n_tests = n_tests + 1;
            if (e.rel ? (cyc != last_pulse + 8) : (cyc < e.lo || cyc > e.hi)) begin
               n_fail = n_fail + 1;
               $display("FAIL pulse_time: at cycle %0d, required %0d..%0d (prev %0d, rel %0d)",
                        cyc, e.lo, e.hi, last_pulse, e.rel);
            end
         end
         last_pulse = cyc;
      end
   end

   // Global time bound.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      reset    = 1'b1;
      run_mode = 1'b0;
      step_btn = 1'b0;
      halt     = 1'b0;

      // Reset then idle.
      wait_cycles(2);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_cpu_en", 16'(cpu_en), 16'd0);
         chk("idle_count", 16'(step_count), 16'd0);
         chk("idle_state", 16'(state_dbg), 16'd0);
      end

      // Clean step, then release producing nothing.
      step_press(20, 15);
      chk("clean_count", 16'(step_count), 16'd1);
      check_drained("clean_missing");

      // Bounce rejection: toggling every 2 cycles never settles.
      for (int i = 0; i < 20; i++) begin
         step_btn = ((i / 2) % 2) == 0;
         @(negedge clk);
      end
      step_press(15, 12);
      chk("bounce_count", 16'(step_count), 16'd2);
      check_drained("bounce_missing");

      // Free-run: first pulse 11 cycles after the switch, then every 8.
      c = cyc;
      run_mode = 1'b1;
      push_exp(2'b01, c + 10, c + 12, 1'b0);
      for (int k = 1; k < 12; k++) push_exp(2'b01, 0, 0, 1'b1);
      wait_cycles(5);
      chk("run_state", 16'(state_dbg), 16'd1);
      while (cyc < c + 30) @(negedge clk);
      step_btn = 1'b1;                 // ignored while running
      wait_cycles(20);
      step_btn = 1'b0;

      // Halt asserted ahead of the tick that would produce pulse 13.
      while (cyc < c + 105) @(negedge clk);
      chk("run_count", 16'(step_count), 16'(4'd14));
      halt = 1'b1;
      wait_cycles(2);
      chk("halt_state", 16'(state_dbg), 16'd2);
      check_drained("run_missing");
      halt = 1'b0;
      wait_cycles(20);
      chk("halt_hold_state", 16'(state_dbg), 16'd2);
      run_mode = 1'b0;
      wait_cycles(5);
      chk("halt_exit_state", 16'(state_dbg), 16'd0);
      step_press(12, 12);
      chk("halt_step_count", 16'(step_count), 16'(4'd15));
      check_drained("halt_step_missing");

      // Wrap: 16 steps from reset bring the 4-bit count back to 0.
      reset = 1'b1;
      wait_cycles(2);
      reset = 1'b0;
      exp_count = 4'd0;
      chk("rst2_count", 16'(step_count), 16'd0);
      for (int i = 0; i < 16; i++) step_press(12, 12);
      chk("wrap_count", 16'(step_count), 16'd0);
      check_drained("wrap_missing");

      // Reset during a press still being debounced: no pulse.
      step_press(4, 0);
      exp_q.delete();
      exp_count = 4'd0;
      reset    = 1'b1;
      step_btn = 1'b0;
      @(negedge clk);
      chk("midrst_cpu_en", 16'(cpu_en), 16'd0);
      chk("midrst_count", 16'(step_count), 16'd0);
      chk("midrst_state", 16'(state_dbg), 16'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_cycles(20);
      chk("post_rst_count", 16'(step_count), 16'd0);
      chk("post_rst_state", 16'(state_dbg), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pipe_step_ctrl
`default_nettype wire
